// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
//   Shared definitions for the instruction-fetch stage: bus widths, the zero
//   word used as a NOP / cleared value, the reset-enable level, the fetch FSM
//   state encoding and the default first-fetch address.
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int InstAddrBus = 32;  // instruction address width
    localparam int InstBus     = 32;  // instruction word width

    localparam logic [InstBus-1:0]     ZeroWord       = 32'h0000_0000;
    localparam logic                   RstEnable      = 1'b1;
    localparam logic [InstAddrBus-1:0] DefaultResetPc = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] PcStep         = 32'd4;

    // Fetch FSM: one idle cycle out of reset, then alternate between issuing
    // a request and waiting for its single response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; redirect targets drop their low bits.
    function automatic logic [InstAddrBus-1:0] align_word(
        input logic [InstAddrBus-1:0] addr
    );
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Instruction-fetch stage. Issues one instruction-ROM request at a time,
//   buffers the returned word together with its address and presents it to
//   the IF/ID register. Decode can redirect the stream at any time; a
//   response that belongs to the old stream is dropped.
//
// Parameters
//   RESET_PC        first fetch address after reset
// Ports
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   stall           IF/ID holds this cycle and does not consume the buffer
//   branch_flag_i   redirect request from decode (highest priority)
//   branch_target_i redirect address (low two bits ignored)
//   rom_req_o       instruction-ROM request
//   rom_addr_o      request address (always the current pc)
//   rom_gnt_i       ROM accepts the request this cycle
//   rom_rvalid_i    ROM response valid
//   rom_rdata_i     ROM response word
//   if_pc           address of the buffered instruction (0 when empty)
//   if_inst         buffered instruction (0 / NOP when empty)
//   if_valid        buffer holds a valid instruction
// -----------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = DefaultResetPc
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   rom_req_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [InstBus-1:0]     rom_rdata_i,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_valid
);

    fetch_state_t           state;
    logic [InstAddrBus-1:0] pc;         // next address to request
    logic [InstAddrBus-1:0] fetch_pc;   // address of the outstanding request
    logic                   discard;    // outstanding response is stale
    logic                   buf_valid;
    logic [InstAddrBus-1:0] buf_pc;
    logic [InstBus-1:0]     buf_inst;

    logic                   grant;
    logic                   load;
    logic [InstAddrBus-1:0] branch_pc;

    // The request must drop in the same cycle a full buffer is stalled, so it
    // is decoded from the state and the live stall input rather than
    // registered.
    assign rom_req_o  = (state == REQ) && (!buf_valid || !stall);
    assign rom_addr_o = pc;

    assign grant      = rom_req_o && rom_gnt_i;
    // A response is kept only if it belongs to the current stream and no
    // redirect arrives alongside it.
    assign load       = (state == WAIT) && rom_rvalid_i && !discard && !branch_flag_i;
    assign branch_pc  = align_word(branch_target_i);

    // An empty buffer reads as address 0 with a NOP.
    assign if_valid   = buf_valid;
    assign if_pc      = buf_valid ? buf_pc   : ZeroWord;
    assign if_inst    = buf_valid ? buf_inst : ZeroWord;

    // NOTE: state registers use non-blocking assignments so every branch
    // below sees the pre-edge values, and a later assignment to the same
    // register in this block overrides an earlier one -- that ordering is
    // what gives the redirect its priority.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            fetch_pc  <= ZeroWord;
            discard   <= 1'b0;
            buf_valid <= 1'b0;
            buf_pc    <= ZeroWord;
            buf_inst  <= ZeroWord;
        end else begin
            // Downstream consumes the buffer; a same-edge load overrides.
            if (buf_valid && !stall) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                end

                REQ: begin
                    if (grant) begin
                        state    <= WAIT;
                        fetch_pc <= pc;
                        pc       <= pc + PcStep;
                        // A redirect on the grant edge makes this request stale.
                        discard  <= branch_flag_i;
                    end
                end

                WAIT: begin
                    if (rom_rvalid_i) begin
                        // The single outstanding response has returned, so
                        // any stale marker is spent either way.
                        state   <= REQ;
                        discard <= 1'b0;
                        if (load) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= fetch_pc;
                            buf_inst  <= rom_rdata_i;
                        end
                    end else if (branch_flag_i) begin
                        discard <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Redirect wins over the increment and over any load or hold.
            if (branch_flag_i) begin
                pc        <= branch_pc;
                buf_valid <= 1'b0;
            end
        end
    end

endmodule
